// File: rtl/hog_pkg.sv
// Shared constants for the HOG pipeline stages: Q8 tangent thresholds for the
// 20-degree bin edges, kernel neighbour indices and a small popcount helper.
package hog_pkg;

  localparam int unsigned T20       = 93;
  localparam int unsigned T40       = 215;
  localparam int unsigned T60       = 443;
  localparam int unsigned T80       = 1452;
  localparam int unsigned Q8_SHIFT  = 8;
  localparam int unsigned CMP_WIDTH = 20;
  localparam int unsigned NUM_BINS  = 9;

  // Kernel pixel index (r*3+c) of the four centre neighbours
  localparam int unsigned IDX_TOP    = 1;  // (0,1)
  localparam int unsigned IDX_LEFT   = 3;  // (1,0)
  localparam int unsigned IDX_RIGHT  = 5;  // (1,2)
  localparam int unsigned IDX_BOTTOM = 7;  // (2,1)

  function automatic logic [2:0] count4(input logic [3:0] f);
    count4 = 3'(f[0]) + 3'(f[1]) + 3'(f[2]) + 3'(f[3]);
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Valid/enable generator for one elastic pipeline stage: the stage loads when
// it is empty or when the stage after it is loading on the same cycle.
module pipe_stage_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic next_load,
  output logic load,
  output logic valid
);

  assign load = !valid || next_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
    end
  end

endmodule

// File: rtl/grad_bin.sv
// HOG gradient stage: centred-difference Gx/Gy on a 3x3 kernel, L1 magnitude
// and 9-bin unsigned orientation, three register stages with backpressure.
module grad_bin
  import hog_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int BLOCK_WIDTH = 3,
  parameter int MAG_WIDTH   = PIXEL_WIDTH + 1,
  parameter int BIN_WIDTH   = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         k_valid,
  output logic                                         k_ready,
  input  logic [BLOCK_WIDTH*BLOCK_WIDTH*PIXEL_WIDTH-1:0] kernel,
  input  logic                                         k_border,
  output logic                                         g_valid,
  input  logic                                         g_ready,
  output logic [MAG_WIDTH-1:0]                         mag,
  output logic [BIN_WIDTH-1:0]                         bin,
  output logic                                         g_border
);

  logic ld1, ld2, ld3;
  logic v1, v2;

  pipe_stage_ctrl u_s1 (.clk(clk), .rst(rst), .in_valid(k_valid), .next_load(ld2),
                        .load(ld1), .valid(v1));
  pipe_stage_ctrl u_s2 (.clk(clk), .rst(rst), .in_valid(v1), .next_load(ld3),
                        .load(ld2), .valid(v2));
  pipe_stage_ctrl u_s3 (.clk(clk), .rst(rst), .in_valid(v2), .next_load(g_ready),
                        .load(ld3), .valid(g_valid));

  assign k_ready = ld1;

  // ---------------- S1: gradients, fold, absolute values ----------------
  logic [PIXEL_WIDTH-1:0] p_l, p_r, p_t, p_b;
  logic                   unused_pixels;

  assign p_l = kernel[IDX_LEFT*PIXEL_WIDTH   +: PIXEL_WIDTH];
  assign p_r = kernel[IDX_RIGHT*PIXEL_WIDTH  +: PIXEL_WIDTH];
  assign p_t = kernel[IDX_TOP*PIXEL_WIDTH    +: PIXEL_WIDTH];
  assign p_b = kernel[IDX_BOTTOM*PIXEL_WIDTH +: PIXEL_WIDTH];
  assign unused_pixels = ^{kernel[0 +: PIXEL_WIDTH], kernel[2*PIXEL_WIDTH +: PIXEL_WIDTH],
                           kernel[4*PIXEL_WIDTH +: PIXEL_WIDTH], kernel[6*PIXEL_WIDTH +: PIXEL_WIDTH],
                           kernel[8*PIXEL_WIDTH +: PIXEL_WIDTH]};

  logic signed [PIXEL_WIDTH:0] gx, gy, fx, fy;
  logic                        flip;
  logic [PIXEL_WIDTH-1:0]      ax_n, ay_n;

  always_comb begin
    gx   = $signed({1'b0, p_r}) - $signed({1'b0, p_l});
    gy   = $signed({1'b0, p_b}) - $signed({1'b0, p_t});
    flip = gy[PIXEL_WIDTH] || (gy == '0 && gx[PIXEL_WIDTH]);
    fx   = flip ? -gx : gx;
    fy   = flip ? -gy : gy;
    ax_n = PIXEL_WIDTH'(fx[PIXEL_WIDTH] ? -fx : fx);
    ay_n = PIXEL_WIDTH'(fy);
  end

  logic [PIXEL_WIDTH-1:0] ax1, ay1;
  logic                   xneg1, zero1, bord1;

  always_ff @(posedge clk) begin
    if (ld1 && k_valid) begin
      ax1   <= ax_n;
      ay1   <= ay_n;
      xneg1 <= fx[PIXEL_WIDTH];
      zero1 <= (gx == '0) && (gy == '0);
      bord1 <= k_border;
    end
  end

  // ---------------- S2: tangent compares and magnitude ----------------
  // |Gx|+|Gy| equals |fx|+|fy|, so the magnitude is taken after the fold.
  logic [CMP_WIDTH-1:0] l_term;
  logic [3:0]           ge_n;

  always_comb begin
    l_term  = CMP_WIDTH'(ay1) << Q8_SHIFT;
    ge_n[0] = l_term >= CMP_WIDTH'(T20) * CMP_WIDTH'(ax1);
    ge_n[1] = l_term >= CMP_WIDTH'(T40) * CMP_WIDTH'(ax1);
    ge_n[2] = l_term >= CMP_WIDTH'(T60) * CMP_WIDTH'(ax1);
    ge_n[3] = l_term >= CMP_WIDTH'(T80) * CMP_WIDTH'(ax1);
  end

  logic [3:0]           ge2;
  logic [MAG_WIDTH-1:0] mag2;
  logic                 xneg2, zero2, bord2;

  always_ff @(posedge clk) begin
    if (ld2 && v1) begin
      ge2   <= ge_n;
      mag2  <= MAG_WIDTH'(ax1) + MAG_WIDTH'(ay1);
      xneg2 <= xneg1;
      zero2 <= zero1;
      bord2 <= bord1;
    end
  end

  // ---------------- S3: bin encode and output register ----------------
  // A zero gradient passes every L>=R compare, so it needs its own override.
  logic [BIN_WIDTH-1:0] bin_n;
  logic [MAG_WIDTH-1:0] mag_n;

  always_comb begin
    if (bord2 || zero2) begin
      bin_n = '0;
    end else if (xneg2) begin
      bin_n = BIN_WIDTH'(4) + BIN_WIDTH'(count4(~ge2));
    end else begin
      bin_n = BIN_WIDTH'(count4(ge2));
    end
    mag_n = bord2 ? '0 : mag2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag      <= '0;
      bin      <= '0;
      g_border <= 1'b0;
    end else if (ld3 && v2) begin
      mag      <= mag_n;
      bin      <= bin_n;
      g_border <= bord2;
    end
  end

endmodule

// File: tb/tb_grad_bin.sv
// Self-checking bench for grad_bin: directed angle/latency cases, stall and
// stream ordering via a scoreboard, border passthrough and mid-stream reset.
`timescale 1ns/1ps
module tb_grad_bin;

  localparam int PW = 8;
  localparam int KW = 9 * PW;

  typedef struct packed {
    logic [8:0] mag;
    logic [3:0] bin;
    logic       border;
  } res_t;

  logic          clk = 1'b0;
  logic          rst, k_valid, k_ready, k_border, g_valid, g_ready, g_border;
  logic [KW-1:0] kernel;
  logic [8:0]    mag;
  logic [3:0]    bin;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  grad_bin #(.PIXEL_WIDTH(PW), .BLOCK_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .k_valid(k_valid), .k_ready(k_ready), .kernel(kernel),
    .k_border(k_border), .g_valid(g_valid), .g_ready(g_ready), .mag(mag),
    .bin(bin), .g_border(g_border)
  );

  function automatic logic [KW-1:0] mk_kernel(input int l, input int r, input int t,
                                               input int b, input int fill);
    logic [KW-1:0] k;
    for (int i = 0; i < 9; i++) k[i*PW +: PW] = 8'(fill);
    k[3*PW +: PW] = 8'(l);
    k[5*PW +: PW] = 8'(r);
    k[1*PW +: PW] = 8'(t);
    k[7*PW +: PW] = 8'(b);
    return k;
  endfunction

  function automatic logic [KW-1:0] rand_kernel();
    logic [KW-1:0] k;
    for (int i = 0; i < 9; i++) k[i*PW +: PW] = 8'($urandom_range(0, 255));
    return k;
  endfunction

  // Reference: angle thresholds from Q8 tangents, integer arithmetic
  function automatic res_t model(input logic [KW-1:0] k, input logic bd);
    int   tans[4];
    int   gx, gy, ax, cnt;
    res_t r;
    tans = '{93, 215, 443, 1452};
    gx = int'(k[5*PW +: PW]) - int'(k[3*PW +: PW]);
    gy = int'(k[7*PW +: PW]) - int'(k[1*PW +: PW]);
    r.mag    = 9'((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy));
    r.border = bd;
    cnt = 0;
    if (gy < 0 || (gy == 0 && gx < 0)) begin
      gx = -gx;
      gy = -gy;
    end
    ax = gx < 0 ? -gx : gx;
    if (bd) begin
      r.mag = '0;
    end else if (!(gx == 0 && gy == 0)) begin
      for (int b = 0; b < 4; b++) begin
        if (gx >= 0) begin
          if (gy * 256 >= tans[b] * ax) cnt++;
        end else begin
          if (gy * 256 < tans[b] * ax) cnt++;
        end
      end
      if (gx < 0) cnt += 4;
    end
    r.bin = 4'(cnt);
    return r;
  endfunction

  // Scoreboard: push on acceptance, pop on output transfer
  always @(negedge clk) begin
    res_t got, exp;
    if (rst) begin
      sb.delete();
    end else begin
      if (g_valid && g_ready) begin
        checks++;
        got = {mag, bin, g_border};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: output mag=%0d bin=%0d border=%0d with nothing expected",
                   mag, bin, g_border);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_order: got mag=%0d bin=%0d border=%0d expected mag=%0d bin=%0d border=%0d",
                     got.mag, got.bin, got.border, exp.mag, exp.bin, exp.border);
          end
        end
      end
      if (k_valid && k_ready) sb.push_back(model(kernel, k_border));
    end
  end

  task automatic send_one(input logic [KW-1:0] kern, input logic bd,
                          output int lat, output res_t got);
    logic acc = 1'b0;
    k_valid  = 1'b1;
    kernel   = kern;
    k_border = bd;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = k_ready;
    end
    @(posedge clk);
    #1 k_valid = 1'b0;
    lat = acc ? -1 : -2;
    got = '0;
    if (acc) begin
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (g_valid) begin
          lat = n;
          got = {mag, bin, g_border};
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; k_valid = 1'b0; k_border = 1'b0; g_ready = 1'b1; kernel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (g_valid !== 1'b0) begin errors++; $display("FAIL reset_g_valid: got %b expected 0", g_valid); end
    checks++;
    if (mag !== 9'd0) begin errors++; $display("FAIL reset_mag: got %0d expected 0", mag); end
    checks++;
    if (bin !== 4'd0) begin errors++; $display("FAIL reset_bin: got %0d expected 0", bin); end
    checks++;
    if (g_border !== 1'b0) begin errors++; $display("FAIL reset_g_border: got %b expected 0", g_border); end
    checks++;
    if (k_ready !== 1'b1) begin errors++; $display("FAIL reset_k_ready: got %b expected 1", k_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    int   vl[7]   = '{10,  7, 77, 50, 30,   0,   0};
    int   vr[7]   = '{50,  7, 77, 30, 50, 100, 100};
    int   vt[7]   = '{20, 20, 77, 10, 30,   0,   0};
    int   vb[7]   = '{20, 50, 77, 30, 10,  36,  37};
    int   emag[7] = '{40, 30,  0, 40, 40, 136, 137};
    int   ebin[7] = '{ 0,  4,  0,  6,  6,   0,   1};
    int   lat;
    res_t got;
    g_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_one(mk_kernel(vl[i], vr[i], vt[i], vb[i], 77), 1'b0, lat, got);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 3", i, lat); end
      checks++;
      if (got.mag !== 9'(emag[i])) begin
        errors++; $display("FAIL dir%0d_mag: got %0d expected %0d", i, got.mag, emag[i]);
      end
      checks++;
      if (got.bin !== 4'(ebin[i])) begin
        errors++; $display("FAIL dir%0d_bin: got %0d expected %0d", i, got.bin, ebin[i]);
      end
      checks++;
      if (got.border !== 1'b0) begin
        errors++; $display("FAIL dir%0d_border: got %b expected 0", i, got.border);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    logic [KW-1:0] cur;
    logic          acc;
    logic          prev_stall = 1'b0;
    logic [13:0]   prev = '0;
    int            accepts = 0;
    cur = rand_kernel();
    k_border = 1'b0;
    for (int i = 0; i < 45; i++) begin
      g_ready = !((i < 5) || (i >= 20 && i < 25));
      k_valid = (i < 38);
      kernel  = cur;
      @(negedge clk);
      acc = k_valid && k_ready;
      if (i < 5 && acc) accepts++;
      if (i == 4) begin
        checks++;
        if (accepts !== 3) begin errors++; $display("FAIL stall_absorb: got %0d accepts expected 3", accepts); end
        checks++;
        if (k_ready !== 1'b0) begin errors++; $display("FAIL stall_k_ready_empty: got %b expected 0", k_ready); end
      end
      if (i == 22) begin
        checks++;
        if (k_ready !== 1'b0) begin errors++; $display("FAIL stall_k_ready_full: got %b expected 0", k_ready); end
      end
      if (prev_stall) begin
        checks++;
        if ({g_valid, mag, bin, g_border} !== {1'b1, prev}) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b out=%h expected valid=1 out=%h",
                   g_valid, {mag, bin, g_border}, prev);
        end
      end
      prev_stall = g_valid && !g_ready;
      prev       = {mag, bin, g_border};
      @(posedge clk);
      #1;
      if (acc) cur = rand_kernel();
    end
    g_ready = 1'b1;
    k_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL stall_drain: got %0d pending expected 0", sb.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_border();
    logic [KW-1:0] ks[3];
    logic          bds[3] = '{1'b0, 1'b1, 1'b0};
    res_t          exp[3];
    res_t          got[3];
    int            n = 0;
    ks[0] = mk_kernel(10, 50, 20, 20, 3);
    ks[1] = mk_kernel(10, 50, 20, 20, 3);
    ks[2] = mk_kernel(50, 30, 10, 30, 3);
    exp[0] = {9'd40, 4'd0, 1'b0};
    exp[1] = {9'd0,  4'd0, 1'b1};
    exp[2] = {9'd40, 4'd6, 1'b0};
    g_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k_valid  = 1'b1;
      kernel   = ks[i];
      k_border = bds[i];
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        if (k_ready) break;
      end
      @(posedge clk);
      #1;
    end
    k_valid  = 1'b0;
    k_border = 1'b0;
    for (int w = 0; w < 12 && n < 3; w++) begin
      @(negedge clk);
      if (g_valid) begin
        got[n] = {mag, bin, g_border};
        n++;
      end
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL border_count: got %0d outputs expected 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i < n && got[i] !== exp[i]) begin
        errors++;
        $display("FAIL border_out%0d: got mag=%0d bin=%0d border=%0d expected mag=%0d bin=%0d border=%0d",
                 i, got[i].mag, got[i].bin, got[i].border, exp[i].mag, exp[i].bin, exp[i].border);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    int   lat;
    int   stale = 0;
    res_t got;
    g_ready  = 1'b1;
    k_border = 1'b0;
    k_valid  = 1'b1;
    kernel   = mk_kernel(0, 200, 0, 100, 9);
    @(negedge clk);
    @(posedge clk);
    #1 kernel = mk_kernel(200, 0, 100, 0, 9);
    @(negedge clk);
    @(posedge clk);
    #1;
    k_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (g_valid !== 1'b0) begin errors++; $display("FAIL rstmid_g_valid: got %b expected 0", g_valid); end
    checks++;
    if (k_ready !== 1'b1) begin errors++; $display("FAIL rstmid_k_ready: got %b expected 1", k_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (g_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL rstmid_stale: got %0d stale outputs expected 0", stale); end
    @(posedge clk);
    #1;
    send_one(mk_kernel(10, 50, 20, 20, 0), 1'b0, lat, got);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rstmid_latency: got %0d expected 3", lat); end
    checks++;
    if (got !== {9'd40, 4'd0, 1'b0}) begin
      errors++; $display("FAIL rstmid_result: got mag=%0d bin=%0d expected mag=40 bin=0", got.mag, got.bin);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_border();
    test_reset_midstream();
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
